// File: rtl/uart_transmitter_fifo.sv
// UART transmitter with a transmit FIFO, compile-time payload width and per-frame
// parity / stop-bit configuration latched when each word is popped.
module uart_transmitter_fifo #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(SYMBOL_EDGE_TIME);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] CLK_LAST      = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [NW-1:0] FULL_COUNT    = NW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_DATA_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] payload, input logic odd);
    frame_parity = (^payload) ^ odd;
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic                 push_s, pop_s, load_s, fifo_empty_s, symbol_edge_s;

  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_bit_q, parity_bit_d;
  logic                 parity_en_q, parity_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 serial_out_q, serial_out_d;
  logic                 unused_upper_s;

  // Payload bits above DATA_BITS-1 are deliberately dropped at the FIFO input.
  assign unused_upper_s = ^data_in;

  assign data_in_ready = (count_q != FULL_COUNT);
  assign push_s        = data_in_valid & data_in_ready;
  assign fifo_empty_s  = (count_q == NW'(0));
  assign symbol_edge_s = (clk_cnt_q == CLK_LAST);
  assign fifo_count    = count_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign serial_out    = serial_out_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next-state, bit/clock counters and frame datapath
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_bit_d = parity_bit_q;
    parity_en_d  = parity_en_q;
    two_stop_d   = two_stop_q;
    load_s       = 1'b0;
    pop_s        = 1'b0;

    if (state_q == S_IDLE || symbol_edge_s) begin
      clk_cnt_d = CW'(0);
    end else begin
      clk_cnt_d = clk_cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          load_s  = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (symbol_edge_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (symbol_edge_s && bit_cnt_q == LAST_DATA_BIT) begin
          state_d = parity_en_q ? S_PARITY : S_STOP;
        end else if (symbol_edge_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          shift_d   = shift_q >> 1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (symbol_edge_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        // Last stop bit chains straight into the next start bit when work is queued.
        if (symbol_edge_s && bit_cnt_q == {3'b000, two_stop_q}) begin
          if (!fifo_empty_s) begin
            load_s  = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else if (symbol_edge_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_s) begin
      pop_s        = 1'b1;
      shift_d      = mem_q[rd_ptr_q];
      parity_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      parity_bit_d = frame_parity(mem_q[rd_ptr_q], parity_mode == 2'b10);
      two_stop_d   = two_stop;
    end else begin
      pop_s = 1'b0;
    end

    if (state_d != state_q) begin
      bit_cnt_d = 4'd0;
    end else begin
      bit_cnt_d = bit_cnt_d;
    end
  end

  // Line level for the upcoming cycle, registered so serial_out is glitch-free
  always_comb begin
    serial_out_d = 1'b1;
    case (state_d)
      S_IDLE:   serial_out_d = 1'b1;
      S_START:  serial_out_d = 1'b0;
      S_DATA:   serial_out_d = shift_d[0];
      S_PARITY: serial_out_d = parity_bit_d;
      S_STOP:   serial_out_d = 1'b1;
      default:  serial_out_d = 1'b1;
    endcase
  end

  // State, counter, FIFO pointer and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= CW'(0);
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      parity_bit_q <= 1'b0;
      parity_en_q  <= 1'b0;
      two_stop_q   <= 1'b0;
      serial_out_q <= 1'b1;
      wr_ptr_q     <= AW'(0);
      rd_ptr_q     <= AW'(0);
      count_q      <= NW'(0);
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_bit_q <= parity_bit_d;
      parity_en_q  <= parity_en_d;
      two_stop_q   <= two_stop_d;
      serial_out_q <= serial_out_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_in[DATA_BITS-1:0];
    end
  end

endmodule
